// File: rtl/sc_et_pkg.sv
// ---------------------------------------------------------------------------
// sc_et_pkg
// Shared types and helpers for the early-terminated SBC job sequencer.
//   state_e    : sequencer states (IDLE, CLEAR, RUN, DRAIN, HOLD)
//   clamp_prec : maps a requested precision onto the legal range 1..max_p
// ---------------------------------------------------------------------------
package sc_et_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // A zero-length run is meaningless, and a run longer than the converter
  // width would overflow its estimate, so clamp into 1..max_p.
  function automatic int clamp_prec(input int p, input int max_p);
    int r;
    if (p == 32'sd0) begin
      r = 32'sd1;
    end else if (p > max_p) begin
      r = max_p;
    end else begin
      r = p;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_et_ctrl_if.sv
// ---------------------------------------------------------------------------
// sc_et_ctrl_if
// Bundles the job request, converter/SNG control and result handshake of
// the sequencer.
//   slave  : the sequencer (sc_et_ctrl)
//   master : the surrounding front-end / converter slice
// Signals:
//   start_valid/start_ready/start_prec : job request handshake
//   abort                              : cancel running job
//   sbc_clr/sbc_en/sbc_done            : converter + SNG control
//   sbc_done_p2/sbc_bz                 : converter acknowledge and estimate
//   res_valid/res_ready/res_data/res_prec/res_err : result handshake
//   busy                               : sequencer not idle
// ---------------------------------------------------------------------------
interface sc_et_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH + 1)
);
  logic             start_valid;
  logic             start_ready;
  logic [PW-1:0]    start_prec;
  logic             abort;
  logic             sbc_clr;
  logic             sbc_en;
  logic             sbc_done;
  logic             sbc_done_p2;
  logic [WIDTH-1:0] sbc_bz;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [PW-1:0]    res_prec;
  logic             res_err;
  logic             busy;

  modport slave (
    input  start_valid, start_prec, abort, sbc_done_p2, sbc_bz, res_ready,
    output start_ready, sbc_clr, sbc_en, sbc_done, res_valid, res_data,
           res_prec, res_err, busy
  );

  modport master (
    output start_valid, start_prec, abort, sbc_done_p2, sbc_bz, res_ready,
    input  start_ready, sbc_clr, sbc_en, sbc_done, res_valid, res_data,
           res_prec, res_err, busy
  );
endinterface

// File: rtl/sc_et_ctrl.sv
// ---------------------------------------------------------------------------
// sc_et_ctrl
// Job sequencer for one progressive-precision stochastic-to-binary converter.
// A request with precision p clears the converter for one cycle, enables it
// for exactly 2^p cycles (done asserted on the last one), lets it settle for
// one cycle while the estimate is captured, then offers the result on a
// valid/ready port.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sc_et_ctrl_if.slave (request, converter control, result)
// ---------------------------------------------------------------------------
module sc_et_ctrl
  import sc_et_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  sc_et_ctrl_if.slave bus
);

  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;       // one extra bit so 2^WIDTH fits
  logic [PW-1:0]    prec_q, prec_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [PW-1:0]    res_prec_q, res_prec_d;
  logic             res_err_q, res_err_d;
  logic             term_s;

  // Terminal RUN cycle: counter started at 1, so it equals 2^p on cycle 2^p.
  assign term_s = (cnt_q == (CNT_ONE << prec_q));

  // Control outputs decode straight from the state register.
  assign bus.start_ready = (state_q == IDLE);
  assign bus.sbc_clr     = (state_q == CLEAR);
  assign bus.sbc_en      = (state_q == RUN) && !bus.abort;
  assign bus.sbc_done    = (state_q == RUN) && term_s;
  assign bus.res_valid   = (state_q == HOLD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_data    = res_data_q;
  assign bus.res_prec    = res_prec_q;
  assign bus.res_err     = res_err_q;

  // Next-state, counter and result-capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prec_d     = prec_q;
    res_data_d = res_data_q;
    res_prec_d = res_prec_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          prec_d  = PW'(clamp_prec(int'(bus.start_prec), WIDTH));
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_ONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (term_s) begin
          // A missing acknowledge is reported, never compensated by
          // extending the run.
          cnt_d     = cnt_q + CNT_ONE;
          res_err_d = ~bus.sbc_done_p2;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DRAIN: begin
        res_data_d = bus.sbc_bz;
        res_prec_d = prec_q;
        state_d    = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, precision and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prec_q     <= '0;
      res_data_q <= '0;
      res_prec_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prec_q     <= prec_d;
      res_data_q <= res_data_d;
      res_prec_q <= res_prec_d;
      res_err_q  <= res_err_d;
    end
  end

endmodule

// File: tb/tb_sc_et_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_et_ctrl
// Self-checking bench for sc_et_ctrl with a converter stub. The expected
// run length, latency and result fields come from a job-level model.
// ---------------------------------------------------------------------------
module tb_sc_et_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  logic [7:0] stub_bz;
  bit         stub_nack;

  int checks;
  int failures;

  // Model of the result registers (only completed jobs update them).
  logic [7:0] exp_data;
  int         exp_prec;
  int         exp_err;

  sc_et_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sc_et_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Converter stub: acknowledges done unless told not to; its estimate
  // moves while enabled and settles to stub_bz when halted.
  assign bus.sbc_done_p2 = stub_nack ? 1'b0 : bus.sbc_done;
  assign bus.sbc_bz      = bus.sbc_en ? ~stub_bz : stub_bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_prec(input int p_raw);
    if (p_raw == 0) return 1;
    if (p_raw > WIDTH) return WIDTH;
    return p_raw;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start_ready"}, bus.start_ready, 32'd1);
    check_eq({tag, "_busy"},        bus.busy,        32'd0);
    check_eq({tag, "_sbc_en"},      bus.sbc_en,      32'd0);
    check_eq({tag, "_sbc_clr"},     bus.sbc_clr,     32'd0);
    check_eq({tag, "_sbc_done"},    bus.sbc_done,    32'd0);
    check_eq({tag, "_res_valid"},   bus.res_valid,   32'd0);
    check_eq({tag, "_res_data"},    bus.res_data,    32'd0);
    check_eq({tag, "_res_prec"},    bus.res_prec,    32'd0);
    check_eq({tag, "_res_err"},     bus.res_err,     32'd0);
  endtask

  // One job; called and returns at a negedge.
  task automatic run_job(input int p_raw, input logic [7:0] bz, input bit nack,
                         input int abort_at, input int hold);
    int  pc, len, n, en_c, done_c, clr_c, bad;
    bit  got, aborted;
    logic [7:0] held;
    pc  = model_prec(p_raw);
    len = 1 << pc;
    stub_bz   = bz;
    stub_nack = nack;
    bus.res_ready = (hold == 0);
    n = 0;
    while (!bus.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_ready", bus.start_ready, 32'd1);
    bus.start_valid = 1'b1;
    bus.start_prec  = 4'(p_raw);
    @(posedge clk);
    #1 bus.start_valid = 1'b0;
    en_c = 0; done_c = 0; clr_c = 0; got = 0; aborted = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        got = 1;
        break;
      end
      if (bus.sbc_en)   en_c++;
      if (bus.sbc_done) done_c++;
      if (bus.sbc_clr)  clr_c++;
      if (abort_at > 0 && bus.sbc_en && en_c == abort_at) begin
        bus.abort = 1'b1;
        #1 check_eq("abort_en_drop", bus.sbc_en, 32'd0);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check_eq("abort_idle", bus.busy, 32'd0);
        aborted = 1;
        break;
      end
      if (!bus.busy) break;
    end
    if (aborted) begin
      bad = 0;
      for (int i = 0; i < len + 4; i++) begin
        @(negedge clk);
        if (bus.res_valid) bad++;
      end
      check_eq("abort_no_result", bad, 32'd0);
      check_eq("abort_res_data", bus.res_data, exp_data);
      check_eq("abort_res_prec", bus.res_prec, exp_prec);
      check_eq("abort_res_err",  bus.res_err,  exp_err);
      bus.res_ready = 1'b1;
      return;
    end
    check_eq("res_valid_seen", got, 32'd1);
    check_eq("latency", n, len + 2);
    check_eq("en_cycles", en_c, len);
    check_eq("done_cycles", done_c, 32'd1);
    check_eq("clr_cycles", clr_c, 32'd1);
    exp_data = bz;
    exp_prec = pc;
    exp_err  = nack ? 1 : 0;
    check_eq("res_data", bus.res_data, exp_data);
    check_eq("res_prec", bus.res_prec, exp_prec);
    check_eq("res_err",  bus.res_err,  exp_err);
    held = bus.res_data;
    bad  = 0;
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = (i == 0 && hold >= 2);
      @(negedge clk);
      if (!bus.res_valid || bus.start_ready || bus.res_data !== held) bad++;
    end
    bus.start_valid = 1'b0;
    check_eq("hold_stable", bad, 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_eq("release_valid", bus.res_valid, 32'd0);
    check_eq("release_idle",  bus.busy,      32'd0);
  endtask

  int first_hs, second_hs, hs, p_raw, pcr, ab, hd;

  initial begin
    checks = 0; failures = 0;
    exp_data = 8'h00; exp_prec = 0; exp_err = 0;
    stub_bz = 8'h00; stub_nack = 1'b0;
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.start_prec  = 4'd0;
    bus.abort       = 1'b0;
    bus.res_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed jobs.
    run_job(3,  8'hA5, 1'b0, 0, 0);
    run_job(0,  8'h11, 1'b0, 0, 0);
    run_job(12, 8'hC3, 1'b0, 0, 0);
    run_job(2,  8'h77, 1'b1, 0, 0);
    run_job(5,  8'h2E, 1'b0, 0, 0);
    run_job(4,  8'h99, 1'b0, 3, 0);
    run_job(3,  8'h4B, 1'b0, 0, 20);

    // Reset pulse in the middle of a run.
    stub_bz = 8'hF0; stub_nack = 1'b0;
    bus.start_valid = 1'b1;
    bus.start_prec  = 4'd5;
    @(posedge clk);
    #1 bus.start_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_reset_running", bus.sbc_en, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    exp_data = 8'h00; exp_prec = 0; exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(3, 8'h3C, 1'b0, 0, 0);

    // Back-to-back throughput with start_valid held high.
    stub_bz = 8'h5A; stub_nack = 1'b0;
    bus.res_ready   = 1'b1;
    bus.start_valid = 1'b1;
    bus.start_prec  = 4'd2;
    hs = 0; first_hs = -1; second_hs = -1;
    for (int k = 0; k < 60 && hs < 2; k++) begin
      if (bus.start_ready) begin
        if (hs == 0) first_hs = k;
        else second_hs = k;
        hs++;
      end
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    check_eq("throughput", second_hs - first_hs, 32'd8);
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    check_eq("throughput_done", bus.busy, 32'd0);
    exp_data = 8'h5A; exp_prec = 2; exp_err = 0;
    check_eq("throughput_data", bus.res_data, exp_data);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      p_raw = $urandom_range(0, 9);
      pcr   = model_prec(p_raw);
      ab    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 1 << pcr) : 0;
      hd    = $urandom_range(0, 4);
      run_job(p_raw, 8'($urandom), ($urandom_range(0, 4) == 0), ab, hd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
